// File: rtl/sms_ram_arb.sv
// Purpose : shares one single-port SMS SRAM bank between two requesters,
//           using round-robin or fixed priority with a starvation override.
// Latency : grant is combinational (0 cycles); read data and rvalid follow 1 cycle later.
// Backpressure: a requester holds rqN_sel until its rqN_gnt. The loser waits at
//           most 1 cycle in round-robin mode and STARVE_MAX cycles in fixed mode.
//
// Ports:
//   i_sys_hclk, i_sys_rst_b      clock and async active-low reset
//   arb_mode                     0 = round-robin, 1 = fixed priority (rq0 high)
//   rqN_sel/write/addr/size/wdata  requester N access request
//   rqN_gnt                      access issued to the bank this cycle
//   rqN_rvalid/rqN_rdata         read return, one cycle after the grant
//   ram_*                        bank macro interface
//   ram_idle                     no request pending and no read in flight
//   starve_cnt_o                 debug view of the starvation counter
module sms_ram_arb #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_sys_hclk,
  input  logic              i_sys_rst_b,
  input  logic              arb_mode,
  input  logic              rq0_sel,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [2:0]        rq0_size,
  input  logic [31:0]       rq0_wdata,
  input  logic              rq1_sel,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [2:0]        rq1_size,
  input  logic [31:0]       rq1_wdata,
  output logic              rq0_gnt,
  output logic              rq1_gnt,
  output logic              rq0_rvalid,
  output logic              rq1_rvalid,
  output logic [31:0]       rq0_rdata,
  output logic [31:0]       rq1_rdata,
  output logic              ram_sel,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        ram_size,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ram_idle,
  output logic [3:0]        starve_cnt_o
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic       r_last_gnt;
  logic [3:0] r_starve_cnt;
  logic       r_rd_pend;
  logic       r_rd_owner;

  logic       w_pick1;
  logic       w_rd_gnt;

  // Tie-break only: which requester wins when both are eligible.
  // Fixed mode hands rq1 one grant once it has lost STARVE_MAX times in a row.
  assign w_pick1 = arb_mode ? (r_starve_cnt == LP_STARVE_MAX) : ~r_last_gnt;

  assign rq0_gnt = rq0_sel & (~rq1_sel | ~w_pick1);
  assign rq1_gnt = rq1_sel & (~rq0_sel |  w_pick1);
  assign ram_sel = rq0_gnt | rq1_gnt;

  always_comb begin
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_size  = 3'b000;
    ram_wdata = 32'h0;
    if (rq1_gnt) begin
      ram_write = rq1_write;
      ram_addr  = rq1_addr;
      ram_size  = rq1_size;
      ram_wdata = rq1_wdata;
    end else if (rq0_gnt) begin
      ram_write = rq0_write;
      ram_addr  = rq0_addr;
      ram_size  = rq0_size;
      ram_wdata = rq0_wdata;
    end
  end

  assign w_rd_gnt = ram_sel & ~ram_write;

  // Arbitration history. Only real grants touch these, so a retracted
  // request cannot disturb last_gnt or starve_cnt.
  always_ff @(posedge i_sys_hclk or negedge i_sys_rst_b) begin
    if (!i_sys_rst_b) begin
      r_last_gnt   <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      if (ram_sel) begin
        r_last_gnt <= rq1_gnt;
      end
      if (!arb_mode) begin
        r_starve_cnt <= 4'd0;
      end else if (rq1_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (rq1_sel && (r_starve_cnt < LP_STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // One read can be in flight; a new grant every cycle simply re-arms it.
  always_ff @(posedge i_sys_hclk or negedge i_sys_rst_b) begin
    if (!i_sys_rst_b) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_owner <= rq1_gnt;
      end
    end
  end

  assign rq0_rvalid   = r_rd_pend & ~r_rd_owner;
  assign rq1_rvalid   = r_rd_pend &  r_rd_owner;
  assign rq0_rdata    = ram_rdata;
  assign rq1_rdata    = ram_rdata;
  assign ram_idle     = ~rq0_sel & ~rq1_sel & ~r_rd_pend;
  assign starve_cnt_o = r_starve_cnt;

endmodule

// File: tb/tb_sms_ram_arb.sv
// Directed bench for sms_ram_arb. A behavioural bank model answers reads one
// cycle after the select; expected read returns are queued at grant time and
// popped by an independent monitor when an rvalid appears.
module tb_sms_ram_arb;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        arb_mode = 1'b0;
  logic        rq0_sel = 1'b0, rq0_write = 1'b0;
  logic [15:0] rq0_addr = '0;
  logic [2:0]  rq0_size = 3'b010;
  logic [31:0] rq0_wdata = '0;
  logic        rq1_sel = 1'b0, rq1_write = 1'b0;
  logic [15:0] rq1_addr = '0;
  logic [2:0]  rq1_size = 3'b010;
  logic [31:0] rq1_wdata = '0;
  logic        rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid;
  logic [31:0] rq0_rdata, rq1_rdata;
  logic        ram_sel, ram_write, ram_idle;
  logic [15:0] ram_addr;
  logic [2:0]  ram_size;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [3:0]  starve_cnt_o;

  sms_ram_arb #(.ADDR_W(16), .STARVE_MAX(4)) dut (
    .i_sys_hclk(clk), .i_sys_rst_b(rst_b), .arb_mode(arb_mode),
    .rq0_sel(rq0_sel), .rq0_write(rq0_write), .rq0_addr(rq0_addr),
    .rq0_size(rq0_size), .rq0_wdata(rq0_wdata),
    .rq1_sel(rq1_sel), .rq1_write(rq1_write), .rq1_addr(rq1_addr),
    .rq1_size(rq1_size), .rq1_wdata(rq1_wdata),
    .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt),
    .rq0_rvalid(rq0_rvalid), .rq1_rvalid(rq1_rvalid),
    .rq0_rdata(rq0_rdata), .rq1_rdata(rq1_rdata),
    .ram_sel(ram_sel), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_size(ram_size), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_idle(ram_idle), .starve_cnt_o(starve_cnt_o)
  );

  always #5 clk = ~clk;

  // Bank model: untouched words read as A5A5_00xx with xx = addr >> 4.
  logic [31:0] wmem [logic [15:0]];
  always @(posedge clk) begin
    if (ram_sel) begin
      if (ram_write) wmem[ram_addr] = ram_wdata;
      else ram_rdata <= wmem.exists(ram_addr) ? wmem[ram_addr]
                                              : (32'hA5A5_0000 | 32'(ram_addr >> 4));
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] cyc_n = '0;
  always @(posedge clk) cyc_n = cyc_n + 1;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    logic [31:0] cyc;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Monitor: every rvalid must match the oldest queued read, in its cycle.
  always @(negedge clk) begin
    if (rst_b) begin
      if (rq0_rvalid || rq1_rvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_rvalid: got rvalid0=%0b rvalid1=%0b expected none (cycle %0d)",
                   rq0_rvalid, rq1_rvalid, cyc_n);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk("rvalid_pair", {30'b0, rq1_rvalid, rq0_rvalid}, e.owner ? 32'd2 : 32'd1);
          chk("rdata", e.owner ? rq1_rdata : rq0_rdata, e.data);
          chk("rvalid_cycle", cyc_n, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
        rd_exp_t e;
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_rvalid: got none expected owner %0d data 0x%08h at cycle %0d",
                 e.owner, e.data, e.cyc);
      end
    end
  end

  // One arbitration cycle: apply inputs, check the combinational grant and
  // bank outputs mid-cycle, queue the expected read return, step past the edge.
  task automatic cyc(input logic mode,
                     input logic s0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                     input logic s1, input logic w1, input logic [15:0] a1, input logic [31:0] d1,
                     input logic eg0, input logic eg1, input logic [31:0] erd);
    rd_exp_t e;
    arb_mode = mode;
    rq0_sel = s0; rq0_write = w0; rq0_addr = a0; rq0_wdata = d0;
    rq1_sel = s1; rq1_write = w1; rq1_addr = a1; rq1_wdata = d1;
    @(negedge clk);
    chk("rq0_gnt", {31'b0, rq0_gnt}, {31'b0, eg0});
    chk("rq1_gnt", {31'b0, rq1_gnt}, {31'b0, eg1});
    chk("ram_sel", {31'b0, ram_sel}, {31'b0, eg0 | eg1});
    if (eg0 || eg1) begin
      chk("ram_addr", {16'b0, ram_addr}, {16'b0, eg1 ? a1 : a0});
      chk("ram_write", {31'b0, ram_write}, {31'b0, eg1 ? w1 : w0});
      chk("ram_size", {29'b0, ram_size}, 32'd2);
      if (eg1 ? w1 : w0) chk("ram_wdata", ram_wdata, eg1 ? d1 : d0);
      else begin
        e.owner = eg1; e.data = erd; e.cyc = cyc_n + 1;
        exp_q.push_back(e);
      end
    end else begin
      chk("ram_addr_idle", {16'b0, ram_addr}, 32'd0);
      chk("ram_write_idle", {31'b0, ram_write}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_starve(input logic [3:0] exp);
    chk("starve_cnt", {28'b0, starve_cnt_o}, {28'b0, exp});
  endtask

  localparam logic [31:0] D10 = 32'hA5A5_0001;
  localparam logic [31:0] D30 = 32'hA5A5_0003;
  localparam logic [31:0] D40 = 32'hA5A5_0004;
  localparam logic [31:0] D50 = 32'hA5A5_0005;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid0", {31'b0, rq0_rvalid}, 32'd0);
    chk("rst_rvalid1", {31'b0, rq1_rvalid}, 32'd0);
    chk_starve(4'd0);
    chk("rst_idle", {31'b0, ram_idle}, 32'd1);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Single rq0 read of 0x0010
    cyc(0, 1,0,16'h0010,0, 0,0,0,0, 1,0, D10);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0);

    // Round-robin, both reading: rq1 wins the first tie (last_gnt = 0)
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc(0, 1,0,16'h0030,0, 1,0,16'h0040,0, 0,1, D40);
      else            cyc(0, 1,0,16'h0030,0, 1,0,16'h0040,0, 1,0, D30);
    end

    // Fixed priority, STARVE_MAX = 4: four rq0 grants, one forced rq1 grant
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1,0,16'h0010,0, 1,0,16'h0050,0, 1,0, D10);
      chk_starve(4'(i + 1));
    end
    cyc(1, 1,0,16'h0010,0, 1,0,16'h0050,0, 0,1, D50);
    chk_starve(4'd0);
    cyc(1, 1,0,16'h0010,0, 1,0,16'h0050,0, 1,0, D10);
    chk_starve(4'd1);
    cyc(1, 0,0,0,0, 0,0,0,0, 0,0, 0);
    chk_starve(4'd1);

    // rq0 word write, then rq1 reads the same word back
    cyc(0, 1,1,16'h0020,32'hDEAD_BEEF, 0,0,0,0, 1,0, 0);
    cyc(0, 0,0,0,0, 1,0,16'h0020,0, 0,1, 32'hDEAD_BEEF);

    // Mode switch with starve_cnt = 3
    for (int i = 0; i < 3; i++) cyc(1, 1,0,16'h0010,0, 1,0,16'h0050,0, 1,0, D10);
    chk_starve(4'd3);
    cyc(0, 1,0,16'h0010,0, 1,0,16'h0050,0, 0,1, D50);
    chk_starve(4'd0);
    cyc(0, 1,0,16'h0010,0, 1,0,16'h0050,0, 1,0, D10);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0);
    chk("idle_after_drain", {31'b0, ram_idle}, 32'd1);

    // Reset in the cycle after a granted rq1 read (sets last_gnt = 1)
    cyc(0, 0,0,0,0, 1,0,16'h0040,0, 0,1, D40);
    rq1_sel = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("rst_mid_rvalid1", {31'b0, rq1_rvalid}, 32'd0);
    chk("rst_mid_rvalid0", {31'b0, rq0_rvalid}, 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk_starve(4'd0);
    chk("post_rst_idle", {31'b0, ram_idle}, 32'd1);
    chk("post_rst_rvalid1", {31'b0, rq1_rvalid}, 32'd0);
    // last_gnt back at 0, so rq1 wins the first tie again
    cyc(0, 1,0,16'h0030,0, 1,0,16'h0040,0, 0,1, D40);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0);
    cyc(0, 0,0,0,0, 0,0,0,0, 0,0, 0);

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sms_ram_arb.md
# sms_ram_arb

Two-requester arbiter that shares one single-port SMS SRAM bank between two bank-side masters. Typical masters are an AHB slave port and a DMA/BIST port. The block sits between the requesters' RAM-request interfaces (sel/write/addr/size/wdata) and the bank macro. It grants at most one access per cycle, using either round-robin or fixed priority with an anti-starvation override. It returns read data with a per-requester valid pulse one cycle after the grant.

## Interface
Parameters:
- ADDR_W, 16, RAM address width.
- STARVE_MAX, 4, in fixed mode, the number of consecutive lost arbitrations by requester 1 before it receives one forced grant; legal range 1..15.

Ports:
- i_sys_hclk  in  1  clock; all state updates on the rising edge.
- i_sys_rst_b  in  1  asynchronous active-low reset.
- arb_mode  in  1  0 = round-robin; 1 = fixed priority, requester 0 high, with starvation override.
- rq0_sel / rq1_sel  in  1  access request; held until the matching gnt.
- rq0_write / rq1_write  in  1  1 = write, 0 = read.
- rq0_addr / rq1_addr  in  ADDR_W  byte address.
- rq0_size / rq1_size  in  3  HSIZE encoding: 000 byte, 001 halfword, 010 word.
- rq0_wdata / rq1_wdata  in  32  write data, valid in the request cycle.
- rq0_gnt / rq1_gnt  out  1  combinational; access issued to the RAM this cycle.
- rq0_rvalid / rq1_rvalid  out  1  registered; read data valid this cycle.
- rq0_rdata / rq1_rdata  out  32  both driven from ram_rdata; qualify with rvalid.
- ram_sel  out  1  bank select.
- ram_write  out  1  bank write enable.
- ram_addr  out  ADDR_W  bank address.
- ram_size  out  3  bank access size.
- ram_wdata  out  32  bank write data.
- ram_rdata  in  32  bank read data, valid one cycle after a read select.
- ram_idle  out  1  1 when no request is pending and no read is in flight.
- starve_cnt_o  out  4  current starvation count, for debug.

## Operation
- Request/grant:
  - A requester is eligible when its rqN_sel = 1.
  - At most one of rq0_gnt and rq1_gnt is 1 in any cycle.
  - ram_sel = rq0_gnt | rq1_gnt.
  - ram_write, ram_addr, ram_size and ram_wdata are multiplexed from the granted requester.
  - When there is no grant, these four outputs are driven to 0.
- Single eligible requester: granted in the same cycle, in either mode.
- Round-robin (arb_mode = 0) with both eligible:
  - The requester not equal to last_gnt wins.
  - last_gnt is a 1-bit register updated to the winner on every grant; reset value 0, so requester 1 wins the first tie.
- Fixed priority (arb_mode = 1) with both eligible:
  - Requester 0 wins, unless starve_cnt == STARVE_MAX; then requester 1 wins.
- starve_cnt (4 bit):
  - Increments when arb_mode = 1, rq1_sel = 1 and rq1 is not granted.
  - Saturates at STARVE_MAX.
  - Clears on any rq1 grant.
  - Holds when rq1_sel = 0.
  - Forced to 0 whenever arb_mode = 0.
- Read return:
  - On a granted read, rd_pend is set to 1 and rd_owner is set to the granted index.
  - Next cycle: rqN_rvalid = rd_pend & (rd_owner == N).
  - rd_pend clears when no read is granted.
  - Back-to-back reads from alternating requesters each get exactly one rvalid, in grant order.
- Writes produce no rvalid. A write may be granted in the cycle a previous read's data returns.
- ram_idle = ~rq0_sel & ~rq1_sel & ~rd_pend.
- A request is not retracted before its grant. Behaviour after a retraction is undefined but must not corrupt last_gnt or starve_cnt.

## Timing
- Reset values: last_gnt = 0, starve_cnt = 0, rd_pend = 0, rd_owner = 0.
- Reset output values: rq0_rvalid = rq1_rvalid = 0, starve_cnt_o = 0, ram_idle = 1 when no requests are present.
- Grant latency: 0 cycles, combinational from rqN_sel, arb_mode, last_gnt and starve_cnt.
- Read latency: rvalid is asserted exactly 1 cycle after the granting cycle.
- Throughput: one access per cycle, sustained.
- Loser wait bounds:
  - Round-robin: the losing requester waits at most 1 cycle.
  - Fixed mode: requester 1 waits at most STARVE_MAX cycles.
- arb_mode change: takes effect in the same cycle for arbitration; starve_cnt clears on the edge after arb_mode = 0 is sampled.
- Reset asserted mid-read: rvalid drops immediately (asynchronous); the in-flight read is discarded.

## Test plan
- Reset, then rq0 read addr 0x0010 with ram_rdata = 0xA5A5_0001 -> rq0_gnt = 1 in the same cycle, ram_addr = 0x0010, ram_write = 0; next cycle rq0_rvalid = 1 and rq0_rdata = 0xA5A5_0001; rq1_rvalid = 0 throughout.
- Round-robin, both reading continuously for 6 cycles -> grants rq1,rq0,rq1,rq0,rq1,rq0; each rvalid follows its own grant by one cycle; no double grant.
- Fixed mode, both requesting continuously, STARVE_MAX = 4 -> rq0 granted 4 cycles (starve_cnt 1..4), rq1 granted in cycle 5 with starve_cnt reset to 0, then the pattern repeats.
- rq0 write addr 0x0020 wdata 0xDEAD_BEEF, size 010, followed by an rq1 read the next cycle -> ram_wdata = 0xDEADBEEF with ram_write = 1 in cycle 1; rq1 granted in cycle 2; rq1_rvalid in cycle 3; no rq0_rvalid.
- Switch arb_mode 1 -> 0 with starve_cnt = 3 -> starve_cnt_o = 0 on the next edge; round-robin order resumes from last_gnt.
- Assert i_sys_rst_b = 0 in the cycle after a granted read -> rvalid is 0 immediately; after release, all registers are at reset values and ram_idle = 1.
